// File: rtl/i2c_pkg.sv
// Shared types for the single-byte I2C initiator.
//   state_e : transaction sequencer states
//   qtr_e   : quarter-of-bit index (SCL low in Q0/Q1, released in Q2/Q3)
//   RW_*    : encoding of the R/W bit that follows the 7-bit address
package i2c_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StAddr,
    StAddrAck,
    StData,
    StDataAck,
    StStop
  } state_e;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } qtr_e;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_qtr_gen.sv
// Quarter-period generator for the I2C initiator.
//   clk, rst : clock, asynchronous active-high reset
//   en       : count while high; held at Q0 / count 0 while low
//   hold     : freeze the counter (SCL clock stretching)
//   qtr      : current quarter of the bit
//   qtr_end  : high on the last clk cycle of the current quarter
module i2c_qtr_gen
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic hold,
  output qtr_e qtr,
  output logic qtr_end
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  qtr_e             qtr_q, qtr_d;

  assign qtr     = qtr_q;
  assign qtr_end = en && !hold && (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    qtr_d = qtr_q;
    if (!en) begin
      cnt_d = '0;
      qtr_d = Q0;
    end else if (!hold) begin
      if (cnt_q == CntMax) begin
        cnt_d = '0;
        qtr_d = qtr_e'(qtr_q + 2'd1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      qtr_q <= Q0;
    end else begin
      cnt_q <= cnt_d;
      qtr_q <= qtr_d;
    end
  end

endmodule

// File: rtl/i2c_master_byte.sv
// Single-byte I2C initiator: START, addr+R/W, ACK, one data byte, ACK/NACK, STOP.
//   clk, rst       : clock, asynchronous active-high reset
//   req            : start a transaction (taken only when idle)
//   rw, addr, wdata: transaction descriptor, captured with req
//   busy, done     : transaction in progress / one-cycle completion pulse
//   nack           : address or write-data byte not acknowledged (valid with done)
//   rdata          : byte read by the last successful read
//   scl_in, sda_in : sampled bus lines
//   scl_oe, sda_oe : 1 pulls the line low, 0 releases it
// Optional: define I2C_MASTER_CLK_STRETCH_EN to honour target clock stretching.
module i2c_master_byte
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic [7:0] rdata,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe
);

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] wdata_q, wdata_d;
  logic       rw_q, rw_d;
  logic       smp_q, smp_d;
  logic       nack_q, nack_d;
  logic       done_q, done_d;
  logic [7:0] rdata_q, rdata_d;

  qtr_e qtr;
  logic qtr_end;
  logic hold;
  logic bit_end;
  logic smp_now;
  logic low_half;

  assign busy  = (state_q != StIdle);
  assign done  = done_q;
  assign nack  = nack_q;
  assign rdata = rdata_q;

`ifdef I2C_MASTER_CLK_STRETCH_EN
  // Target keeps SCL low after we released it: freeze bit timing.
  assign hold = ((qtr == Q2) || (qtr == Q3)) && !scl_oe && !scl_in;
`else
  assign hold = 1'b0;
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
`endif

  i2c_qtr_gen #(
    .CLK_DIV(CLK_DIV),
    .CNT_W  (CNT_W)
  ) u_qtr_gen (
    .clk    (clk),
    .rst    (rst),
    .en     (busy),
    .hold   (hold),
    .qtr    (qtr),
    .qtr_end(qtr_end)
  );

  assign bit_end  = qtr_end && (qtr == Q3);
  assign smp_now  = qtr_end && (qtr == Q2);
  assign low_half = (qtr == Q0) || (qtr == Q1);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    wdata_d   = wdata_q;
    rw_d      = rw_q;
    smp_d     = smp_q;
    nack_d    = nack_q;
    done_d    = 1'b0;
    rdata_d   = rdata_q;

    if (smp_now) smp_d = sda_in;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StStart;
          sh_d    = {addr, rw};
          wdata_d = wdata;
          rw_d    = rw;
          nack_d  = 1'b0;
        end
      end
      StStart: begin
        if (bit_end) state_d = StAddr;
      end
      StAddr: begin
        if (bit_end) begin
          sh_d = {sh_q[6:0], 1'b0};
          if (bit_cnt_q == 3'd0) state_d = StAddrAck;
        end
      end
      StAddrAck: begin
        if (bit_end) begin
          if (smp_q) begin
            nack_d  = 1'b1;
            state_d = StStop;
          end else begin
            state_d = StData;
            sh_d    = (rw_q == RW_READ) ? 8'h00 : wdata_q;
          end
        end
      end
      StData: begin
        // Reads shift in at the sample point; writes shift out at bit end.
        if (rw_q == RW_READ) begin
          if (smp_now) sh_d = {sh_q[6:0], sda_in};
        end else if (bit_end) begin
          sh_d = {sh_q[6:0], 1'b0};
        end
        if (bit_end && (bit_cnt_q == 3'd0)) state_d = StDataAck;
      end
      StDataAck: begin
        if (bit_end) begin
          state_d = StStop;
          if (rw_q == RW_READ) rdata_d = sh_q;
          else if (smp_q)      nack_d  = 1'b1;
        end
      end
      StStop: begin
        if (bit_end) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Bit counter restarts at 7 on every state change.
    if (state_d != state_q) begin
      bit_cnt_d = 3'd7;
    end else if (bit_end && ((state_q == StAddr) || (state_q == StData))) begin
      bit_cnt_d = bit_cnt_q - 3'd1;
    end
  end

  // Bus drive is decoded from registered state only, so reset releases both
  // lines immediately.
  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    unique case (state_q)
      StIdle: begin
      end
      StStart: begin
        sda_oe = (qtr == Q2) || (qtr == Q3);
      end
      StAddr: begin
        scl_oe = low_half;
        sda_oe = !sh_q[7];
      end
      StAddrAck, StDataAck: begin
        scl_oe = low_half;
      end
      StData: begin
        scl_oe = low_half;
        sda_oe = (rw_q == RW_WRITE) && !sh_q[7];
      end
      StStop: begin
        scl_oe = (qtr == Q0);
        sda_oe = (qtr != Q3);
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= 3'd0;
      sh_q      <= 8'h00;
      wdata_q   <= 8'h00;
      rw_q      <= RW_WRITE;
      smp_q     <= 1'b0;
      nack_q    <= 1'b0;
      done_q    <= 1'b0;
      rdata_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      wdata_q   <= wdata_d;
      rw_q      <= rw_d;
      smp_q     <= smp_d;
      nack_q    <= nack_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_i2c_master_byte.sv
// Bench for i2c_master_byte: open-drain bus with pull-ups, a bit-level target
// model, and a scoreboard of expected transaction results.
module tb_i2c_master_byte;

  localparam int unsigned CLK_DIV = 4;

  typedef struct {
    logic [7:0] addr_byte;
    logic [7:0] data_byte;
    logic       rd;
    logic       nack;
    logic [7:0] rdata;
    int         lat;
    int         rises;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] addr = 7'h00;
  logic [7:0] wdata = 8'h00;
  logic       busy, done, nack, scl_oe, sda_oe;
  logic [7:0] rdata;
  logic       s_scl_low = 1'b0;
  logic       s_sda_low = 1'b0;
  logic       scl_bus, sda_bus;

  assign scl_bus = ~(scl_oe | s_scl_low);
  assign sda_bus = ~(sda_oe | s_sda_low);

  i2c_master_byte #(
    .CLK_DIV(CLK_DIV),
    .CNT_W  (16)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .rw    (rw),
    .addr  (addr),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .nack  (nack),
    .rdata (rdata),
    .scl_in(scl_bus),
    .sda_in(sda_bus),
    .scl_oe(scl_oe),
    .sda_oe(sda_oe)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb[$];
  int   exp_done = 0;
  logic [7:0] model_rdata = 8'h00;

  // Monitor: sampled on the falling edge.
  int   cyc = 0, t_busy = 0, done_cnt = 0, done_long = 0, lat_at_done = 0;
  logic busy_prev = 1'b0, done_prev = 1'b0;
  logic nack_at_done = 1'b0, busy_at_done = 1'b0;
  logic [7:0] rdata_at_done = 8'h00;

  always @(negedge clk) begin
    cyc       <= cyc + 1;
    busy_prev <= busy;
    done_prev <= done;
    if (busy && !busy_prev) t_busy <= cyc;
    if (done) begin
      done_cnt      <= done_cnt + 1;
      lat_at_done   <= cyc - t_busy;
      nack_at_done  <= nack;
      rdata_at_done <= rdata;
      busy_at_done  <= busy;
      if (done_prev) done_long <= done_long + 1;
    end
  end

  // Target model.
  logic       ack_addr = 1'b1, ack_data = 1'b1, stretch_en = 1'b0;
  logic [7:0] s_rdata = 8'h00;
  logic       scl_p, sda_p, in_xfer, stop_seen, s_rd, stretch_arm;
  logic       cap [0:31];
  int         idx, rd_drive_err, stretch_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_p <= 1'b1; sda_p <= 1'b1; in_xfer <= 1'b0; stop_seen <= 1'b0; s_rd <= 1'b0;
      idx <= 0; rd_drive_err <= 0; s_sda_low <= 1'b0; s_scl_low <= 1'b0;
      stretch_arm <= 1'b0; stretch_cnt <= 0;
    end else begin
      scl_p <= scl_bus;
      sda_p <= sda_bus;
      if (scl_p && scl_bus && sda_p && !sda_bus) begin
        in_xfer <= 1'b1; idx <= 0; stop_seen <= 1'b0; s_sda_low <= 1'b0;
      end else if (scl_p && scl_bus && !sda_p && sda_bus) begin
        in_xfer <= 1'b0; stop_seen <= 1'b1; s_sda_low <= 1'b0;
      end else if (in_xfer) begin
        if (!scl_p && scl_bus) begin
          if (idx < 32) cap[idx] <= sda_bus;
          if (idx == 7) s_rd <= sda_bus;
          if (s_rd && idx >= 9 && idx <= 17 && sda_oe) rd_drive_err <= rd_drive_err + 1;
          idx <= idx + 1;
        end
        if (scl_p && !scl_bus) begin
          if (idx == 8) s_sda_low <= ack_addr;
          else if (idx >= 9 && idx <= 16 && s_rd && ack_addr) s_sda_low <= !s_rdata[16-idx];
          else if (idx == 17 && !s_rd && ack_data) s_sda_low <= 1'b1;
          else s_sda_low <= 1'b0;
          if (idx == 8 && stretch_en) begin
            s_scl_low <= 1'b1; stretch_arm <= 1'b1; stretch_cnt <= 0;
          end
        end
      end
      if (stretch_arm && !scl_oe) begin
        if (stretch_cnt == 9) begin
          s_scl_low <= 1'b0; stretch_arm <= 1'b0;
        end
        stretch_cnt <= stretch_cnt + 1;
      end
    end
  end

  function automatic logic [7:0] cap_byte(input int s);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = cap[s+i];
    return b;
  endfunction

  // Drive one request starting right after a falling edge; record expectations.
  task automatic start_txn(input logic r, input logic [6:0] a, input logic [7:0] d,
                           input logic aa, input logic ad, input logic [7:0] srd,
                           input int extra);
    exp_t e;
    ack_addr = aa; ack_data = ad; s_rdata = srd;
    e.addr_byte = {a, r};
    e.data_byte = r ? srd : d;
    e.rd        = r && aa;
    e.nack      = !aa || (!r && !ad);
    if (aa && r) model_rdata = srd;
    e.rdata = model_rdata;
    e.lat   = (aa ? 80 : 44) * CLK_DIV + extra;
    e.rises = aa ? 19 : 10;
    sb.push_back(e);
    exp_done++;
    req = 1'b1; rw = r; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL accept busy: got %b want 1", busy); else n_pass++;
    n_checks++;
    if (nack !== 1'b0) $display("FAIL accept nack clear: got %b want 0", nack); else n_pass++;
  endtask

  task automatic wait_done(input string nm);
    bit seen = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk); #1;
      if (done_cnt >= exp_done) begin
        seen = 1;
        break;
      end
    end
    n_checks++;
    if (!seen) $display("FAIL %s done timeout: got none want done pulse", nm); else n_pass++;
  endtask

  task automatic check_txn(input string nm);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      $display("FAIL %s scoreboard: got empty want entry", nm);
      return;
    end
    n_pass++;
    e = sb.pop_front();
    n_checks++;
    if (lat_at_done !== e.lat) $display("FAIL %s latency: got %0d want %0d", nm, lat_at_done, e.lat);
    else n_pass++;
    n_checks++;
    if (nack_at_done !== e.nack) $display("FAIL %s nack: got %b want %b", nm, nack_at_done, e.nack);
    else n_pass++;
    n_checks++;
    if (rdata_at_done !== e.rdata) $display("FAIL %s rdata: got %h want %h", nm, rdata_at_done, e.rdata);
    else n_pass++;
    n_checks++;
    if (busy_at_done !== 1'b0) $display("FAIL %s busy at done: got %b want 0", nm, busy_at_done);
    else n_pass++;
    n_checks++;
    if (cap_byte(0) !== e.addr_byte) $display("FAIL %s addr byte: got %h want %h", nm, cap_byte(0), e.addr_byte);
    else n_pass++;
    n_checks++;
    if (idx !== e.rises) $display("FAIL %s scl rises: got %0d want %0d", nm, idx, e.rises);
    else n_pass++;
    n_checks++;
    if (stop_seen !== 1'b1) $display("FAIL %s stop: got %b want 1", nm, stop_seen);
    else n_pass++;
    n_checks++;
    if (done_long !== 0) $display("FAIL %s done width: got %0d long want 0", nm, done_long);
    else n_pass++;
    if (e.rises == 19) begin
      n_checks++;
      if (cap_byte(9) !== e.data_byte) $display("FAIL %s data byte: got %h want %h", nm, cap_byte(9), e.data_byte);
      else n_pass++;
    end
    if (e.rd) begin
      n_checks++;
      if (rd_drive_err !== 0) $display("FAIL %s read sda drive: got %0d want 0", nm, rd_drive_err);
      else n_pass++;
      n_checks++;
      if (cap[17] !== 1'b1) $display("FAIL %s master nack bit: got %b want 1", nm, cap[17]);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    n_checks++;
    if ({busy, done, nack, scl_oe, sda_oe} !== 5'b0)
      $display("FAIL reset flags: got %b want 00000", {busy, done, nack, scl_oe, sda_oe});
    else n_pass++;
    n_checks++;
    if (rdata !== 8'h00) $display("FAIL reset rdata: got %h want 00", rdata); else n_pass++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    start_txn(1'b0, 7'h50, 8'hA5, 1'b1, 1'b1, 8'h00, 0);
    wait_done("write");
    check_txn("write");
  endtask

  task automatic test_read();
    start_txn(1'b1, 7'h3C, 8'h00, 1'b1, 1'b1, 8'h96, 0);
    wait_done("read");
    check_txn("read");
  endtask

  task automatic test_addr_nack();
    start_txn(1'b0, 7'h11, 8'h77, 1'b0, 1'b1, 8'h00, 0);
    wait_done("addr_nack");
    check_txn("addr_nack");
    repeat (20) @(negedge clk);
    #1;
    n_checks++;
    if (nack !== 1'b1) $display("FAIL addr_nack hold: got %b want 1", nack); else n_pass++;
  endtask

  task automatic test_data_nack();
    start_txn(1'b0, 7'h22, 8'h5A, 1'b1, 1'b0, 8'h00, 0);
    wait_done("data_nack");
    check_txn("data_nack");
  endtask

  task automatic test_back_to_back();
    start_txn(1'b0, 7'h15, 8'h3C, 1'b1, 1'b1, 8'h00, 0);
    wait_done("b2b_a");
    start_txn(1'b1, 7'h6A, 8'h00, 1'b1, 1'b1, 8'hC3, 0);
    check_txn("b2b_a");
    wait_done("b2b_b");
    check_txn("b2b_b");
  endtask

  task automatic test_busy_req();
    int base;
    start_txn(1'b0, 7'h2B, 8'hC3, 1'b1, 1'b1, 8'h00, 0);
    repeat (40) @(negedge clk);
    req = 1'b1; addr = 7'h7F; rw = 1'b1;
    @(negedge clk);
    req = 1'b0;
    wait_done("busy_req");
    check_txn("busy_req");
    base = done_cnt;
    repeat (60) @(negedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || done_cnt !== base)
      $display("FAIL busy_req queued: got busy=%b dones=%0d want 0 %0d", busy, done_cnt, base);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int base = done_cnt;
    ack_addr = 1'b1; ack_data = 1'b1;
    req = 1'b1; addr = 7'h11; rw = 1'b0; wdata = 8'h00;
    @(negedge clk);
    req = 1'b0;
    repeat (6) @(negedge clk);
    req = 1'b1; addr = 7'h3C; rw = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (11) @(negedge clk);
    #1;
    n_checks++;
    if ({busy, scl_oe, sda_oe} !== 3'b111)
      $display("FAIL mid_addr drive: got %b want 111", {busy, scl_oe, sda_oe});
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, scl_oe, sda_oe} !== 3'b000)
      $display("FAIL async release: got %b want 000", {busy, scl_oe, sda_oe});
    else n_pass++;
    model_rdata = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (400) @(negedge clk);
    #1;
    n_checks++;
    if (done_cnt !== base || busy !== 1'b0)
      $display("FAIL reset_mid done/busy: got %0d/%b want %0d/0", done_cnt, busy, base);
    else n_pass++;
    n_checks++;
    if (rdata !== 8'h00) $display("FAIL reset_mid rdata: got %h want 00", rdata); else n_pass++;
  endtask

`ifdef I2C_MASTER_CLK_STRETCH_EN
  task automatic test_stretch();
    stretch_en = 1'b1;
    start_txn(1'b0, 7'h50, 8'hA5, 1'b1, 1'b1, 8'h00, 10);
    wait_done("stretch");
    stretch_en = 1'b0;
    check_txn("stretch");
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_addr_nack();
    test_data_nack();
    test_back_to_back();
    test_busy_req();
    test_reset_mid();
`ifdef I2C_MASTER_CLK_STRETCH_EN
    @(negedge clk);
    test_stretch();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
